phy_rx_lane_sync: RTL
=====================

Name: phy_rx_lane_sync

Overview:
Per-lane symbol-lock and lane-alignment controller for the two-lane PHY receive path. It sits between the serial-to-parallel converters (byte rate, clk_4f) and the 8b-to-32b converters. It watches each lane's byte stream for COM training symbols, declares per-lane lock, and checks that both lanes leave training in the same cycle. Only then does it assert sincro and gate data-byte valids into the 8b-to-32b converters.

Parameters:
COM_SYMBOL, 8'hBC, training/comma byte value.
LOCK_COUNT, 4, consecutive valid COM bytes required for lane lock (range 2..15).
LOSS_COUNT, 8, consecutive cycles with valid low, while locked, that drop lock (range 2..255).

Ports:
clk_4f  input  1  byte-rate clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
data_8b_0  input  8  lane 0 byte from serial-to-parallel converter.
valid_8b_0  input  1  lane 0 byte valid.
data_8b_1  input  8  lane 1 byte.
valid_8b_1  input  1  lane 1 byte valid.
valid_out_0  output  1  lane 0 data valid to 8b-to-32b converter (combinational gate).
valid_out_1  output  1  lane 1 data valid.
lane_lock  output  2  bit N = lane N in LOCKED or DATA state.
sincro  output  1  both lanes aligned and in DATA (registered).
skew_err  output  1  one-cycle pulse on lane misalignment.
lock_loss_cnt  output  8  lock-loss event counter (see Optional Feature).

Behaviour:
- Reset (reset low, async): both lane FSMs go to SEARCH. Counters clear. lane_lock=2'b00, sincro=0, skew_err=0, lock_loss_cnt=0.
- Each lane has an identical FSM with states SEARCH, CHECK, LOCKED, DATA, a 4-bit com_cnt and an 8-bit gap_cnt.
- SEARCH: a valid byte equal to COM_SYMBOL moves to CHECK with com_cnt=1. Anything else stays.
- CHECK:
  - Valid COM: com_cnt+1. When com_cnt+1 == LOCK_COUNT, go to LOCKED.
  - Valid non-COM: return to SEARCH, com_cnt=0.
  - valid low: hold state.
- LOCKED: valid COM stays. A valid non-COM byte is the first data byte; the move to DATA is arbitrated globally (below).
- DATA: valid COM bytes are dropped (valid_out stays low) and state is held. Non-COM valid bytes pass.
- gap_cnt (LOCKED/DATA only): increments on valid low and clears on valid high. Reaching LOSS_COUNT sends the lane to SEARCH (a lock-loss event). sincro drops the next cycle, and the other lane also returns to SEARCH.
- Alignment (global):
  - If both lanes are LOCKED and both present a first data byte in the same cycle, both go to DATA. sincro=1 from the next cycle.
  - If exactly one lane presents a first data byte while the other lane is not presenting one, that is skew. skew_err pulses for one cycle and both lanes return to SEARCH.
  - First data on one lane while the other lane is in SEARCH/CHECK is also skew.
- valid_out_N = sincro & valid_8b_N & (data_8b_N != COM_SYMBOL) & lane N in DATA. Zero added latency: data bytes pass through unregistered. The aligning byte itself is not forwarded, because sincro is still 0 in that cycle.
- Simultaneous events: lock-loss on one lane and skew in the same cycle count as one lock-loss event. Both lanes go to SEARCH and skew_err still pulses.
- Reset mid-operation: immediate return to the reset values, regardless of state.

Optional Feature:
- Macro PHY_RX_SYNC_STATS_EN.
- Defined: lock_loss_cnt is an 8-bit saturating counter that increments once per transition out of DATA caused by gap timeout or skew. It holds at 8'hFF and clears only on reset.
- Undefined: lock_loss_cnt is tied to 8'h00 and no counter logic is synthesized.

Test Plan:
1. Training: both lanes send 4 valid 8'hBC then 8'h11/8'h22 in the same cycle -> lane_lock=2'b11 after the 4th COM; sincro=1 the cycle after the first data byte; valid_out_0/1 high for subsequent non-COM bytes only.
2. Broken training: lane 0 sends BC,BC,5A,BC,BC,BC,BC -> lock_lane0 only after the final BC; com_cnt restarted at 5A.
3. Skew: lane 0 sends first data one cycle before lane 1 -> skew_err one-cycle pulse, lane_lock=2'b00, sincro=0, both lanes retrain successfully afterwards.
4. Gap: in DATA, hold valid_8b_1 low for 8 cycles -> both lanes drop to SEARCH on the 8th cycle; sincro=0 the next cycle; lock_loss_cnt=1 with PHY_RX_SYNC_STATS_EN.
5. Async reset asserted mid-DATA between clock edges -> all outputs at reset values immediately; first valid_out only after a full retrain.
6. COM inside data stream in DATA state -> valid_out low for that byte, sincro stays 1.

Source files
------------

// File: rtl/phy_rx_lane_sync_if.sv
// Lane byte bus between the serial-to-parallel converters, the lane sync
// controller and the 8b-to-32b converters.
//
// Handshake: valid-only, no backpressure. A byte is transferred in every
// clk_4f cycle in which its valid is high; data is don't-care otherwise.
// valid_out_N qualifies the same data_8b_N byte towards the 8b-to-32b
// converter in the same cycle.
interface phy_rx_lane_sync_if;
  logic [7:0] data_8b_0;
  logic       valid_8b_0;
  logic [7:0] data_8b_1;
  logic       valid_8b_1;
  logic       valid_out_0;
  logic       valid_out_1;

  modport master (
    output data_8b_0, valid_8b_0, data_8b_1, valid_8b_1,
    input  valid_out_0, valid_out_1
  );

  modport slave (
    input  data_8b_0, valid_8b_0, data_8b_1, valid_8b_1,
    output valid_out_0, valid_out_1
  );
endinterface

// File: rtl/phy_rx_lane_sync.sv
// Two-lane symbol lock and lane alignment controller.
// Each lane runs SEARCH -> CHECK -> LOCKED -> DATA on COM training bytes;
// both lanes must leave training in the same cycle to assert sincro.
// Optional lock-loss statistics counter: define PHY_RX_SYNC_STATS_EN.
module phy_rx_lane_sync #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_COUNT = 8
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  phy_rx_lane_sync_if.slave        bus,
  output logic [1:0]               lane_lock,
  output logic                     sincro,
  output logic                     skew_err,
  output logic [7:0]               lock_loss_cnt,
  output logic [3:0]               lane_state
);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED, DATA} lane_state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [7:0] GAP_LAST = 8'(LOSS_COUNT - 1);

  lane_state_t st_q   [2];
  lane_state_t st_d   [2];
  logic [3:0]  com_q  [2];
  logic [3:0]  com_d  [2];
  logic [7:0]  gap_q  [2];
  logic [7:0]  gap_d  [2];

  logic [7:0]  din        [2];
  logic        vin        [2];
  logic [1:0]  is_com;
  logic [1:0]  is_dat;
  logic [1:0]  first_data;
  logic [1:0]  tracked;
  logic [1:0]  gap_hit;
  logic        skew;
  logic        align;
  logic        drop;

  assign din[0] = bus.data_8b_0;
  assign din[1] = bus.data_8b_1;
  assign vin[0] = bus.valid_8b_0;
  assign vin[1] = bus.valid_8b_1;

  // Per-lane byte classification and the global align / skew / drop decisions
  always_comb begin
    is_com     = '0;
    is_dat     = '0;
    first_data = '0;
    tracked    = '0;
    gap_hit    = '0;
    for (int i = 0; i < 2; i++) begin
      is_com[i]     = vin[i] && (din[i] == COM_SYMBOL);
      is_dat[i]     = vin[i] && (din[i] != COM_SYMBOL);
      first_data[i] = (st_q[i] == LOCKED) && is_dat[i];
      tracked[i]    = (st_q[i] == LOCKED) || (st_q[i] == DATA);
      gap_hit[i]    = tracked[i] && !vin[i] && (gap_q[i] == GAP_LAST);
    end
    // Both lanes are LOCKED whenever both present a first data byte.
    align = first_data[0] && first_data[1];
    skew  = first_data[0] != first_data[1];
    // Any lock loss or misalignment retrains both lanes together.
    drop  = skew || (gap_hit != 2'b00);
  end

  // Lane FSM next state; a global drop overrides everything
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      com_d[i] = com_q[i];
      gap_d[i] = gap_q[i];
      case (st_q[i])
        SEARCH: begin
          com_d[i] = 4'd0;
          if (is_com[i]) begin
            st_d[i]  = CHECK;
            com_d[i] = 4'd1;
          end
        end
        CHECK: begin
          if (is_com[i]) begin
            com_d[i] = com_q[i] + 4'd1;
            if (com_q[i] + 4'd1 == LOCK_CNT) st_d[i] = LOCKED;
          end else if (is_dat[i]) begin
            st_d[i]  = SEARCH;
            com_d[i] = 4'd0;
          end
        end
        LOCKED: begin
          gap_d[i] = vin[i] ? 8'd0 : gap_q[i] + 8'd1;
          if (align) st_d[i] = DATA;
        end
        DATA: begin
          gap_d[i] = vin[i] ? 8'd0 : gap_q[i] + 8'd1;
        end
        default: st_d[i] = SEARCH;
      endcase
      if (drop) begin
        st_d[i]  = SEARCH;
        com_d[i] = 4'd0;
        gap_d[i] = 8'd0;
      end
    end
  end

  // Lane state and counter registers
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= SEARCH;
        com_q[i] <= 4'd0;
        gap_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        com_q[i] <= com_d[i];
        gap_q[i] <= gap_d[i];
      end
    end
  end

  // sincro rises the cycle after alignment, falls the cycle after a drop
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      sincro   <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      skew_err <= skew;
      if (drop)       sincro <= 1'b0;
      else if (align) sincro <= 1'b1;
    end
  end

`ifdef PHY_RX_SYNC_STATS_EN
  // Saturating count of exits from DATA caused by gap timeout or skew
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      lock_loss_cnt <= 8'h00;
    end else if (drop && ((st_q[0] == DATA) || (st_q[1] == DATA))
                 && (lock_loss_cnt != 8'hFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'h01;
    end
  end
`else
  assign lock_loss_cnt = 8'h00;
`endif

  // Data bytes pass through unregistered; COM bytes in DATA are dropped.
  assign bus.valid_out_0 = sincro && is_dat[0] && (st_q[0] == DATA);
  assign bus.valid_out_1 = sincro && is_dat[1] && (st_q[1] == DATA);

  assign lane_lock  = tracked;
  assign lane_state = {st_q[1], st_q[0]};

endmodule
